pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard, forwarding and stall controller for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).
- Keeps its own shadow copy of per-stage hazard metadata: valid, rd, rs1/rs2, regwrite, memread.
- Produces pipeline-register enables, flushes and forwarding selects.
- Adds what the current datapath lacks: load-use interlock, a stall-only mode with no forwarding, a data-memory wait handshake with timeout, and stall/flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 46 ++++
 rtl/hazard_fwd_sel.sv | 38 +++
 rtl/pipe_hazard_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Forwarding select codes, controller FSM encoding, shadow-slot layout and
// the producer/consumer match rule used by both stall and forwarding logic.
package pipe_ctrl_pkg;

    // Operand source selects driven on fwd_a / fwd_b.
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StTimeout = 2'd2
    } ctrl_state_e;

    // Register indices are stored zero-extended to this width so the slot type
    // does not depend on the top-level REG_ADDR_W (which must not exceed it).
    localparam int unsigned SLOT_ADDR_W = 8;

    typedef struct packed {
        logic                   valid;
        logic [SLOT_ADDR_W-1:0] rd;
        logic [SLOT_ADDR_W-1:0] rs1;
        logic [SLOT_ADDR_W-1:0] rs2;
        logic                   use_rs1;
        logic                   use_rs2;
        logic                   regwrite;
        logic                   memread;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

    // A producer satisfies a consumer operand only if it really writes a
    // non-zero register; x0 never creates a dependency.
    function automatic logic producer_match(
        input logic                   valid,
        input logic                   regwrite,
        input logic [SLOT_ADDR_W-1:0] rd,
        input logic [SLOT_ADDR_W-1:0] rs,
        input logic                   use_rs
    );
        return valid && regwrite && (rd != '0) && use_rs && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Combinational forwarding priority selector for one EX operand.
// Ports: rs/use_rs    - EX consumer operand and its use flag
//        mem_*        - producer held in the MEM shadow slot
//        wb_*         - producer held in the WB shadow slot
//        sel          - FWD_EXMEM, FWD_MEMWB or FWD_RF
module hazard_fwd_sel
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  use_rs,
    input  logic                  mem_valid,
    input  logic                  mem_regwrite,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_valid,
    input  logic                  wb_regwrite,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic [1:0]            sel
);

    logic mem_hit;
    logic wb_hit;

    always_comb begin
        mem_hit = mem_valid && mem_regwrite && (mem_rd != '0) && use_rs && (rs == mem_rd);
        wb_hit  = wb_valid && wb_regwrite && (wb_rd != '0) && use_rs && (rs == wb_rd);
        // The younger producer (MEM) holds the newest value.
        if (mem_hit) begin
            sel = FWD_EXMEM;
        end else if (wb_hit) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall controller for the 5-stage RV32 pipeline.
// Tracks shadow hazard metadata for EX/MEM/WB, detects load-use (or any RAW
// hazard in stall-only mode), handles redirect flushes and a data-memory wait
// handshake with sticky timeout, and counts stall/flush cycles.
// Ports: clk, rst (sync, active-high)
//        id_*                 - ID-stage instruction fields
//        redirect             - taken branch/jump resolved in MEM
//        mem_req, mem_ready   - data-memory handshake
//        pc_en, ifid_en       - PC and IF/ID enables
//        *_flush, pipe_hold   - bubble inserts and global freeze
//        fwd_a, fwd_b         - EX operand source selects
//        mem_timeout          - sticky memory timeout flag
//        stall_cnt, flush_cnt - saturating performance counters
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter bit          FWD_EN       = 1'b1,
    parameter int unsigned WAIT_W       = 4,
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  redirect,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic                  pipe_hold,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    slot_t             id_slot;
    slot_t             ex_q, mem_q, wb_q;
    ctrl_state_e       state_q;
    logic [WAIT_W-1:0] wait_q;
    logic              mem_timeout_q;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

    logic ex_hit, mem_hit, raw_stall;
    logic redirect_act, stall_act;

    always_comb begin
        id_slot          = SLOT_BUBBLE;
        id_slot.valid    = id_valid;
        id_slot.rd       = SLOT_ADDR_W'(id_rd);
        id_slot.rs1      = SLOT_ADDR_W'(id_rs1);
        id_slot.rs2      = SLOT_ADDR_W'(id_rs2);
        id_slot.use_rs1  = id_use_rs1;
        id_slot.use_rs2  = id_use_rs2;
        id_slot.regwrite = id_regwrite;
        id_slot.memread  = id_memread;
    end

    // Dependencies of the ID instruction on in-flight producers.
    always_comb begin
        ex_hit  = producer_match(ex_q.valid, ex_q.regwrite, ex_q.rd, id_slot.rs1, id_use_rs1)
               || producer_match(ex_q.valid, ex_q.regwrite, ex_q.rd, id_slot.rs2, id_use_rs2);
        mem_hit = producer_match(mem_q.valid, mem_q.regwrite, mem_q.rd, id_slot.rs1, id_use_rs1)
               || producer_match(mem_q.valid, mem_q.regwrite, mem_q.rd, id_slot.rs2, id_use_rs2);
        if (FWD_EN) begin
            raw_stall = id_valid && ex_q.memread && ex_hit;
        end else begin
            // WB producers need no stall: the regfile writes in the first half-cycle.
            raw_stall = id_valid && (ex_hit || mem_hit);
        end
    end

    // Hold is combinational so the pipeline freezes in the very cycle the
    // memory misses, and releases in the cycle mem_ready arrives.
    always_comb begin
        case (state_q)
            StRun:     pipe_hold = mem_req && !mem_ready;
            StMemWait: pipe_hold = !mem_ready;
            StTimeout: pipe_hold = 1'b1;
            default:   pipe_hold = 1'b1;
        endcase
    end

    always_comb begin
        // Redirect beats load-use: the dependent instruction is squashed anyway.
        redirect_act = redirect && !pipe_hold;
        stall_act    = raw_stall && !redirect && !pipe_hold;
        pc_en        = !pipe_hold && !stall_act;
        ifid_en      = !pipe_hold && !stall_act;
        ifid_flush   = redirect_act;
        idex_flush   = redirect_act || stall_act;
        exmem_flush  = redirect_act;
    end

    if (FWD_EN) begin : g_fwd
        hazard_fwd_sel #(
            .REG_ADDR_W(SLOT_ADDR_W)
        ) u_fwd_a (
            .rs          (ex_q.rs1),
            .use_rs      (ex_q.use_rs1),
            .mem_valid   (mem_q.valid),
            .mem_regwrite(mem_q.regwrite),
            .mem_rd      (mem_q.rd),
            .wb_valid    (wb_q.valid),
            .wb_regwrite (wb_q.regwrite),
            .wb_rd       (wb_q.rd),
            .sel         (fwd_a)
        );
        hazard_fwd_sel #(
            .REG_ADDR_W(SLOT_ADDR_W)
        ) u_fwd_b (
            .rs          (ex_q.rs2),
            .use_rs      (ex_q.use_rs2),
            .mem_valid   (mem_q.valid),
            .mem_regwrite(mem_q.regwrite),
            .mem_rd      (mem_q.rd),
            .wb_valid    (wb_q.valid),
            .wb_regwrite (wb_q.regwrite),
            .wb_rd       (wb_q.rd),
            .sel         (fwd_b)
        );
    end else begin : g_no_fwd
        assign fwd_a = FWD_RF;
        assign fwd_b = FWD_RF;
    end

    // Not every slot field is consumed in every configuration.
    logic unused_slot_bits;
    assign unused_slot_bits = ^{mem_q, wb_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= SLOT_BUBBLE;
            mem_q <= SLOT_BUBBLE;
            wb_q  <= SLOT_BUBBLE;
        end else if (!pipe_hold) begin
            wb_q  <= mem_q;
            mem_q <= exmem_flush ? SLOT_BUBBLE : ex_q;
            ex_q  <= idex_flush ? SLOT_BUBBLE : id_slot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StRun;
            wait_q        <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                StRun: begin
                    if (mem_req && !mem_ready) begin
                        state_q <= StMemWait;
                        wait_q  <= WAIT_W'(1);
                    end
                end
                StMemWait: begin
                    if (mem_ready) begin
                        state_q <= StRun;
                        wait_q  <= '0;
                    end else if (wait_q == WAIT_W'(MEM_WAIT_MAX)) begin
                        state_q       <= StTimeout;
                        mem_timeout_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                StTimeout: begin
                    // Only rst leaves this state.
                end
                default: state_q <= StRun;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((stall_act || pipe_hold) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (redirect_act && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboarded bench: d1 forwards (MEM_WAIT_MAX=4), d0 is stall-only.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic       id_regwrite = 1'b0, id_memread = 1'b0;
    logic       redirect = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;

    logic       pc_en1, ifid_en1, ifid_flush1, idex_flush1, exmem_flush1, pipe_hold1, to1;
    logic [1:0] fwd_a1, fwd_b1;
    logic [7:0] sc1, fc1;
    logic       pc_en0, ifid_en0, ifid_flush0, idex_flush0, exmem_flush0, pipe_hold0, to0;
    logic [1:0] fwd_a0, fwd_b0;
    logic [7:0] sc0, fc0;

    pipe_hazard_ctrl #(
        .REG_ADDR_W(5), .FWD_EN(1'b1), .WAIT_W(4), .MEM_WAIT_MAX(4), .CNT_W(8)
    ) d1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .redirect(redirect),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en1), .ifid_en(ifid_en1),
        .ifid_flush(ifid_flush1), .idex_flush(idex_flush1), .exmem_flush(exmem_flush1),
        .pipe_hold(pipe_hold1), .fwd_a(fwd_a1), .fwd_b(fwd_b1), .mem_timeout(to1),
        .stall_cnt(sc1), .flush_cnt(fc1)
    );

    pipe_hazard_ctrl #(
        .REG_ADDR_W(5), .FWD_EN(1'b0), .WAIT_W(4), .MEM_WAIT_MAX(15), .CNT_W(8)
    ) d0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .redirect(redirect),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en0), .ifid_en(ifid_en0),
        .ifid_flush(ifid_flush0), .idex_flush(idex_flush0), .exmem_flush(exmem_flush0),
        .pipe_hold(pipe_hold0), .fwd_a(fwd_a0), .fwd_b(fwd_b0), .mem_timeout(to0),
        .stall_cnt(sc0), .flush_cnt(fc0)
    );

    // ctl = {pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, pipe_hold, fwd_a, fwd_b, to}
    localparam logic [10:0] C_IDLE   = 11'b11_000_0_00_00_0;
    localparam logic [10:0] C_STALL  = 11'b00_010_0_00_00_0;
    localparam logic [10:0] C_HOLD   = 11'b00_000_1_00_00_0;
    localparam logic [10:0] C_REDIR  = 11'b11_111_0_00_00_0;
    localparam logic [10:0] C_TO     = 11'b00_000_1_00_00_1;
    localparam logic [10:0] C_A_WB   = 11'b11_000_0_10_00_0;
    localparam logic [10:0] C_A_MEM  = 11'b11_000_0_01_00_0;
    localparam logic [10:0] C_AB_MEM = 11'b11_000_0_01_01_0;

    typedef struct {
        int          cyc;
        int          inst;
        string       name;
        logic [10:0] ctl;
        logic [7:0]  sc;
        logic [7:0]  fc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: compare every expectation stamped with the current cycle.
    initial forever begin
        exp_t        e;
        logic [26:0] act, want;
        @(negedge clk);
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            if (e.inst == 1)
                act = {pc_en1, ifid_en1, ifid_flush1, idex_flush1, exmem_flush1, pipe_hold1,
                       fwd_a1, fwd_b1, to1, sc1, fc1};
            else
                act = {pc_en0, ifid_en0, ifid_flush0, idex_flush0, exmem_flush0, pipe_hold0,
                       fwd_a0, fwd_b0, to0, sc0, fc0};
            want = {e.ctl, e.sc, e.fc};
            checks++;
            if (act !== want) begin
                failures++;
                $display("FAIL %s d%0d cyc%0d: got ctl=%b stall=%0d flush=%0d, want ctl=%b stall=%0d flush=%0d",
                         e.name, e.inst, cyc, act[26:16], act[15:8], act[7:0],
                         e.ctl, e.sc, e.fc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input int inst, input string name, input logic [10:0] ctl,
                              input int sc, input int fc);
        exp_t e;
        e.cyc  = cyc;
        e.inst = inst;
        e.name = name;
        e.ctl  = ctl;
        e.sc   = 8'(sc);
        e.fc   = 8'(fc);
        sb.push_back(e);
    endtask

    task automatic set_id(input logic v, input int rd, input int rs1, input int rs2,
                          input logic u1, input logic u2, input logic rw, input logic mr);
        id_valid    = v;
        id_rd       = 5'(rd);
        id_rs1      = 5'(rs1);
        id_rs2      = 5'(rs2);
        id_use_rs1  = u1;
        id_use_rs2  = u2;
        id_regwrite = rw;
        id_memread  = mr;
    endtask

    task automatic do_reset();
        next_cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        redirect  = 1'b0;
        mem_req   = 1'b0;
        mem_ready = 1'b0;
        rst       = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        expect_out(1, "reset_d1", C_IDLE, 0, 0);
        expect_out(0, "reset_d0", C_IDLE, 0, 0);

        // 1: lw x5 then add x6,x5,x1 -> one stall, then MEM/WB forward
        do_reset();
        set_id(1, 5, 2, 0, 1, 0, 1, 1);
        expect_out(1, "t1_lw_issue", C_IDLE, 0, 0);
        next_cycle();
        set_id(1, 6, 5, 1, 1, 1, 1, 0);
        expect_out(1, "t1_loaduse_stall", C_STALL, 0, 0);
        next_cycle();
        expect_out(1, "t1_bubble_in_ex", C_IDLE, 1, 0);
        next_cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        expect_out(1, "t1_fwd_memwb", C_A_WB, 1, 0);

        // 2: addi x3; addi x3; sub x4,x3,x2 -> MEM wins over WB
        do_reset();
        set_id(1, 3, 0, 0, 1, 0, 1, 0);
        expect_out(1, "t2_addi1", C_IDLE, 0, 0);
        next_cycle();
        set_id(1, 3, 1, 0, 1, 0, 1, 0);
        expect_out(1, "t2_addi2", C_IDLE, 0, 0);
        next_cycle();
        set_id(1, 4, 3, 2, 1, 1, 1, 0);
        expect_out(1, "t2_sub_no_stall", C_IDLE, 0, 0);
        next_cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        expect_out(1, "t2_fwd_mem_prio", C_A_MEM, 0, 0);

        // 3: producers of x0 never stall or forward, both modes
        do_reset();
        set_id(1, 0, 1, 0, 1, 0, 1, 1);
        expect_out(1, "t3_lw_x0_d1", C_IDLE, 0, 0);
        expect_out(0, "t3_lw_x0_d0", C_IDLE, 0, 0);
        next_cycle();
        set_id(1, 9, 0, 0, 1, 1, 1, 0);
        expect_out(1, "t3_use_x0_d1", C_IDLE, 0, 0);
        expect_out(0, "t3_use_x0_d0", C_IDLE, 0, 0);
        next_cycle();
        set_id(1, 10, 0, 0, 1, 1, 1, 0);
        expect_out(1, "t3_mem_x0_d1", C_IDLE, 0, 0);
        expect_out(0, "t3_mem_x0_d0", C_IDLE, 0, 0);
        next_cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        expect_out(1, "t3_wb_x0_d1", C_IDLE, 0, 0);

        // 4: redirect beats load-use
        do_reset();
        set_id(1, 5, 2, 0, 1, 0, 1, 1);
        expect_out(1, "t4_lw_issue", C_IDLE, 0, 0);
        next_cycle();
        set_id(1, 6, 5, 1, 1, 1, 1, 0);
        redirect = 1'b1;
        expect_out(1, "t4_redirect_wins", C_REDIR, 0, 0);
        next_cycle();
        redirect = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        expect_out(1, "t4_counters", C_IDLE, 0, 1);

        // 5a: three wait cycles then ready
        do_reset();
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        expect_out(1, "t5_hold_enter", C_HOLD, 0, 0);
        next_cycle();
        expect_out(1, "t5_wait1", C_HOLD, 1, 0);
        next_cycle();
        expect_out(1, "t5_wait2", C_HOLD, 2, 0);
        next_cycle();
        mem_ready = 1'b1;
        expect_out(1, "t5_release", C_IDLE, 3, 0);
        next_cycle();
        mem_req   = 1'b0;
        mem_ready = 1'b0;
        expect_out(1, "t5_back_in_run", C_IDLE, 3, 0);

        // 5b: timeout with MEM_WAIT_MAX=4, sticky until rst
        do_reset();
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            expect_out(1, "t5_wait_to", C_HOLD, k, 0);
            next_cycle();
        end
        expect_out(1, "t5_timeout_set", C_TO, 5, 0);
        next_cycle();
        mem_req   = 1'b0;
        mem_ready = 1'b1;
        redirect  = 1'b1;
        expect_out(1, "t5_sticky_redirect_ignored", C_TO, 6, 0);
        next_cycle();
        redirect = 1'b0;
        expect_out(1, "t5_sticky", C_TO, 7, 0);
        do_reset();
        expect_out(1, "t5_cleared_by_rst", C_IDLE, 0, 0);

        // 6: stall-only, add x7 then sub x8,x7,x7
        do_reset();
        set_id(1, 7, 1, 2, 1, 1, 1, 0);
        expect_out(0, "t6_add", C_IDLE, 0, 0);
        next_cycle();
        set_id(1, 8, 7, 7, 1, 1, 1, 0);
        expect_out(0, "t6_stall1", C_STALL, 0, 0);
        expect_out(1, "t6_fwd_mode_no_stall", C_IDLE, 0, 0);
        next_cycle();
        expect_out(0, "t6_stall2", C_STALL, 1, 0);
        expect_out(1, "t6_fwd_mode_both_mem", C_AB_MEM, 0, 0);
        next_cycle();
        expect_out(0, "t6_release", C_IDLE, 2, 0);
        next_cycle();
        // a reader of x8 stalls only if sub now sits in EX
        set_id(1, 9, 8, 0, 1, 0, 1, 0);
        expect_out(0, "t6_sub_in_ex", C_STALL, 2, 0);

        next_cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
